// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for the comparator binary-search controller:
//   - FSM state encoding (ST_IDLE, ST_PROBE)
//   - default WIDTH / SETTLE values
//   - one-hot {g,l,e} response codes returned by the comparator
// -----------------------------------------------------------------------------
package cmp_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PROBE = 1'b1
    } state_t;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_SETTLE = 1;

    // Comparator response codes, ordered {g, l, e}.
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

endpackage

// File: rtl/cmp_settle_timer.sv
// -----------------------------------------------------------------------------
// cmp_settle_timer
// 4-bit down-counter that measures how long a probe has been held.
// Loading it with SETTLE-1 makes tick assert during the SETTLE-th cycle after
// the load edge; the counter then rests at zero (tick stays high) until the
// next load.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   load      in   reload the counter with load_val (has priority)
//   load_val  in   4-bit reload value (SETTLE-1)
//   tick      out  counter has reached zero
// -----------------------------------------------------------------------------
module cmp_settle_timer
    import cmp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       tick
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign tick = (count == 4'd0);

endmodule

// File: rtl/cmp_search_ctrl.sv
// -----------------------------------------------------------------------------
// cmp_search_ctrl
// Locates the unknown value on an external comparator's a input by binary
// search: drives a probe onto the comparator's b input, waits SETTLE cycles,
// samples {g,l,e} and narrows the [lo, hi] interval until e is seen, the
// interval empties, or an illegal response code appears.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   begin a search (only honoured while busy=0)
//   g,l,e   in   comparator outputs a>b, a<b, a==b
//   probe   out  WIDTH-bit value driven to comparator b (registered)
//   busy    out  search in progress
//   done    out  one-cycle pulse when a search ends
//   found   out  e was seen (valid with/after done)
//   err     out  illegal {g,l,e} code was seen (valid with/after done)
//   result  out  last probe value (valid with/after done)
// -----------------------------------------------------------------------------
module cmp_search_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             g,
    input  logic             l,
    input  logic             e,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    // Bounds carry one extra bit so lo may step past hi (e.g. 2^WIDTH)
    // without wrapping back into range.
    localparam logic [WIDTH:0]   HI_INIT     = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] PROBE_INIT  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0]   ONE_B       = (WIDTH+1)'(1);
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);

    state_t           state, state_nx;
    logic [WIDTH:0]   lo, lo_nx;
    logic [WIDTH:0]   hi, hi_nx;
    logic [WIDTH-1:0] probe_nx;
    logic [WIDTH-1:0] result_nx;
    logic             done_nx;
    logic             found_nx;
    logic             err_nx;
    logic             timer_load;
    logic             tick;

    // Scratch values for the PROBE decision
    logic [2:0]       code;
    logic [WIDTH:0]   lo_upd;
    logic [WIDTH:0]   hi_upd;
    logic             stepped;
    logic             finish;

    // Midpoint of two bounds; the sum of a bound pair never exceeds
    // 2^(WIDTH+1)-1, so the WIDTH+1-bit add cannot overflow.
    function automatic logic [WIDTH-1:0] mid_of(input logic [WIDTH:0] a,
                                                input logic [WIDTH:0] b);
        logic [WIDTH:0] sum;
        sum = a + b;
        return sum[WIDTH:1];
    endfunction

    cmp_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            lo     <= '0;
            hi     <= '0;
            probe  <= '0;
            result <= '0;
            done   <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            lo     <= lo_nx;
            hi     <= hi_nx;
            probe  <= probe_nx;
            result <= result_nx;
            done   <= done_nx;
            found  <= found_nx;
            err    <= err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        lo_nx      = lo;
        hi_nx      = hi;
        probe_nx   = probe;
        result_nx  = result;
        done_nx    = 1'b0;
        found_nx   = found;
        err_nx     = err;
        timer_load = 1'b0;
        code       = {g, l, e};
        lo_upd     = lo;
        hi_upd     = hi;
        stepped    = 1'b0;
        finish     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx   = ST_PROBE;
                    lo_nx      = '0;
                    hi_nx      = HI_INIT;
                    probe_nx   = PROBE_INIT;
                    found_nx   = 1'b0;
                    err_nx     = 1'b0;
                    timer_load = 1'b1;
                end
            end

            ST_PROBE: begin
                if (tick) begin
                    case (code)
                        CMP_EQ: begin
                            result_nx = probe;
                            found_nx  = 1'b1;
                            finish    = 1'b1;
                        end
                        CMP_GT: begin
                            lo_upd  = {1'b0, probe} + ONE_B;
                            stepped = 1'b1;
                        end
                        CMP_LT: begin
                            // a < 0 cannot exist: nothing left to search.
                            if (probe == '0) begin
                                result_nx = probe;
                                finish    = 1'b1;
                            end else begin
                                hi_upd  = {1'b0, probe} - ONE_B;
                                stepped = 1'b1;
                            end
                        end
                        default: begin
                            result_nx = probe;
                            err_nx    = 1'b1;
                            found_nx  = 1'b0;
                            finish    = 1'b1;
                        end
                    endcase

                    if (stepped) begin
                        lo_nx = lo_upd;
                        hi_nx = hi_upd;
                        if (lo_upd > hi_upd) begin
                            result_nx = probe;
                            found_nx  = 1'b0;
                            err_nx    = 1'b0;
                            finish    = 1'b1;
                        end else begin
                            probe_nx   = mid_of(lo_upd, hi_upd);
                            timer_load = 1'b1;
                        end
                    end

                    if (finish) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end

            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_PROBE);

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cmp_search_ctrl
// Two controller instances (SETTLE=1 and SETTLE=3) each paired with a
// behavioural comparator. Expected probe sequences and outcomes come from an
// integer binary-search reference model.
// -----------------------------------------------------------------------------
module tb_cmp_search_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start1, g1, l1, e1, busy1, done1, found1, err1;
    logic [3:0] probe1, result1;
    logic       start3, g3, l3, e3, busy3, done3, found3, err3;
    logic [3:0] probe3, result3;

    int tgt1 = 0, tgt3 = 0;
    int force1 = -1, force3 = -1;

    int n_assert = 0;
    int n_fail   = 0;

    int exp_q[$];
    int obs_q[$];
    int exp_found, exp_err, exp_result;

    logic       use3 = 1'b0;
    logic       m_busy, m_done, m_found, m_err;
    logic [3:0] m_probe, m_result;

    always #5 clk = ~clk;

    cmp_search_ctrl #(.WIDTH(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .g(g1), .l(l1), .e(e1),
        .probe(probe1), .busy(busy1), .done(done1),
        .found(found1), .err(err1), .result(result1)
    );

    cmp_search_ctrl #(.WIDTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .g(g3), .l(l3), .e(e3),
        .probe(probe3), .busy(busy3), .done(done3),
        .found(found3), .err(err3), .result(result3)
    );

    // Behavioural comparators: a = target, b = probe, unless a code is forced.
    always_comb begin
        if (force1 >= 0) begin
            {g1, l1, e1} = force1[2:0];
        end else begin
            g1 = (tgt1 > int'(probe1));
            l1 = (tgt1 < int'(probe1));
            e1 = (tgt1 == int'(probe1));
        end
    end

    always_comb begin
        if (force3 >= 0) begin
            {g3, l3, e3} = force3[2:0];
        end else begin
            g3 = (tgt3 > int'(probe3));
            l3 = (tgt3 < int'(probe3));
            e3 = (tgt3 == int'(probe3));
        end
    end

    assign m_busy   = use3 ? busy3   : busy1;
    assign m_done   = use3 ? done3   : done1;
    assign m_found  = use3 ? found3  : found1;
    assign m_err    = use3 ? err3    : err1;
    assign m_probe  = use3 ? probe3  : probe1;
    assign m_result = use3 ? result3 : result1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: textbook integer binary search over 0..15 with the
    // documented termination rules. Each probe appears `settle` times.
    task automatic model(input int target, input int fcode, input int settle);
        int lo, hi, p, code;
        exp_q.delete();
        exp_found = 0;
        exp_err = 0;
        exp_result = 0;
        lo = 0;
        hi = 15;
        for (int step = 0; step < 16; step++) begin
            p = (lo + hi) / 2;
            for (int s = 0; s < settle; s++) exp_q.push_back(p);
            if (fcode >= 0)       code = fcode;
            else if (target > p)  code = 4;
            else if (target < p)  code = 2;
            else                  code = 1;
            exp_result = p;
            if (code == 1) begin
                exp_found = 1;
                break;
            end else if (code == 4) begin
                lo = p + 1;
            end else if (code == 2) begin
                if (p == 0) break;
                hi = p - 1;
            end else begin
                exp_err = 1;
                break;
            end
            if (lo > hi) break;
        end
    endtask

    // Start a search on the chosen instance at the current (post-negedge)
    // time, collect the probe every cycle while busy, and check the outcome.
    // A nonzero poke raises start again during that busy cycle.
    task automatic run(input bit sel3, input int target, input int fcode, input int poke);
        int  c;
        bit  got_done;
        use3 = sel3;
        if (sel3) begin tgt3 = target; force3 = fcode; end
        else      begin tgt1 = target; force1 = fcode; end
        model(target, fcode, sel3 ? 3 : 1);

        if (sel3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        if (sel3) start3 = 1'b0; else start1 = 1'b0;

        obs_q.delete();
        c = 0;
        got_done = 0;
        while (c < 100) begin
            @(negedge clk);
            c++;
            if (sel3) start3 = 1'b0; else start1 = 1'b0;
            if (m_done) begin
                got_done = 1;
                break;
            end
            obs_q.push_back(int'(m_probe));
            chk("busy_during", m_busy, 1);
            if (c == poke) begin
                if (sel3) start3 = 1'b1; else start1 = 1'b1;
            end
        end
        if (sel3) start3 = 1'b0; else start1 = 1'b0;

        chk("done_seen", got_done, 1);
        chk("latency", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk("probe_seq", obs_q[i], exp_q[i]);
        chk("found", m_found, exp_found);
        chk("err", m_err, exp_err);
        chk("result", m_result, exp_result);
        chk("busy_at_done", m_busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_probe1", probe1, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_done1", done1, 0);
        chk("rst_found1", found1, 0);
        chk("rst_err1", err1, 0);
        chk("rst_result1", result1, 0);
        chk("rst_probe3", probe3, 0);
        chk("rst_busy3", busy3, 0);

        rst_n = 1'b1;
        @(negedge clk);

        // Direct hit on the first probe
        run(0, 7, -1, 0);
        @(negedge clk);
        chk("done_pulse_width", done1, 0);
        chk("found_hold", found1, 1);
        chk("result_hold", result1, 7);
        chk("probe_hold_idle", probe1, 7);

        // Upper edge, lower edge, target above range (g always)
        run(0, 15, -1, 0);
        run(0, 0, -1, 0);
        run(0, 16, -1, 0);
        chk("beyond_not_found", found1, 0);

        // Illegal comparator responses
        run(0, 0, 0, 0);
        run(0, 0, 6, 0);
        chk("err_110", err1, 1);

        // Back-to-back random targets: each start lands in the done cycle
        for (int i = 0; i < 8; i++)
            run(0, int'($urandom_range(15, 0)), -1, 0);
        force1 = -1;

        // SETTLE=3, with a start pulse in the middle of the search
        run(1, 9, -1, 2);
        for (int i = 0; i < 3; i++)
            run(1, int'($urandom_range(15, 0)), -1, 0);

        // Reset during the second probe of a SETTLE=3 search
        @(negedge clk);
        use3 = 1'b1;
        tgt3 = 9;
        force3 = -1;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        repeat (4) @(negedge clk);
        chk("second_probe", probe3, 11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_probe", probe3, 0);
        chk("abort_busy", busy3, 0);
        chk("abort_done", done3, 0);
        chk("abort_found", found3, 0);
        chk("abort_err", err3, 0);
        chk("abort_result", result3, 0);
        @(negedge clk);
        chk("abort_no_done_a", done3, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done_b", done3, 0);
            chk("abort_idle", busy3, 0);
        end
        run(1, 9, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
